// File: rtl/logic_74hc193_updown_counter.sv
// Presettable, cascadable up/down counter in the style of a 74HC193.
// Stages cascade by feeding co_o / bo_o into the next stage's ent_i.
// Optional build macro: LOGIC_UDCNT_SATURATE_EN selects saturating
// counting instead of wrapping at the count limits.
module logic_74hc193_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             ck_i,
  input  logic             nclr_i,
  input  logic             nload_i,
  input  logic             enp_i,
  input  logic             ent_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] datain_i,
  output logic             co_o,
  output logic             bo_o,
  output logic             tc_pulse_o,
  output logic [WIDTH-1:0] counter_o
);

  // Terminal count for the configured range.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  // Next-state selection: load beats count, count beats hold. Clear is applied
  // in the register process so it overrides everything on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (!nload_i) begin
      cnt_d = datain_i;
    end else if (enp_i && ent_i) begin
      if (up_i) begin
        // Out-of-range values are treated like the terminal count going up.
        if (cnt_q >= MaxVal) begin
`ifdef LOGIC_UDCNT_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d = '0;
`endif
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
`ifdef LOGIC_UDCNT_SATURATE_EN
          cnt_d = '0;
`else
          cnt_d = MaxVal;
`endif
          tc_d  = 1'b1;
        end else if (cnt_q > MaxVal) begin
          // Out-of-range value snaps back into range; not a wrap.
          cnt_d = MaxVal;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge ck_i) begin
    if (!nclr_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  // Cascade lookahead outputs are combinational so a ripple chain settles
  // within the cycle; ent_i gates them even while enp_i holds the count.
  always_comb begin
    co_o       = ent_i & up_i & (cnt_q == MaxVal);
    bo_o       = ent_i & ~up_i & (cnt_q == '0);
    tc_pulse_o = tc_q;
    counter_o  = cnt_q;
  end

endmodule

// File: tb/tb_logic_74hc193_updown_counter.sv
// Directed bench for logic_74hc193_updown_counter: a modulus-16 stage, a
// modulus-10 stage and a two-stage modulus-16 cascade share one clock.
// Expected register values are queued as each step is driven and checked
// one clock later.
module tb_logic_74hc193_updown_counter;

`ifdef LOGIC_UDCNT_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic ck = 1'b0;
  always #5 ck = ~ck;

  // Stage A: WIDTH 4, MODULUS 16
  logic       a_nclr, a_nload, a_enp, a_ent, a_up;
  logic [3:0] a_din, a_cnt;
  logic       a_co, a_bo, a_tc;
  // Stage B: WIDTH 4, MODULUS 10
  logic       b_nclr, b_nload, b_enp, b_ent, b_up;
  logic [3:0] b_din, b_cnt;
  logic       b_co, b_bo, b_tc;
  // Cascade: two WIDTH 4 / MODULUS 16 stages
  logic       c_nclr, c_nload, c_enp, c_ent, c_up;
  logic [3:0] c_din, c0_cnt, c1_cnt;
  logic       c0_co, c0_bo, c0_tc, c1_co, c1_bo, c1_tc;

  logic_74hc193_updown_counter #(.WIDTH(4), .MODULUS(16)) u_a (
    .ck_i(ck), .nclr_i(a_nclr), .nload_i(a_nload), .enp_i(a_enp), .ent_i(a_ent),
    .up_i(a_up), .datain_i(a_din), .co_o(a_co), .bo_o(a_bo), .tc_pulse_o(a_tc),
    .counter_o(a_cnt)
  );

  logic_74hc193_updown_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .ck_i(ck), .nclr_i(b_nclr), .nload_i(b_nload), .enp_i(b_enp), .ent_i(b_ent),
    .up_i(b_up), .datain_i(b_din), .co_o(b_co), .bo_o(b_bo), .tc_pulse_o(b_tc),
    .counter_o(b_cnt)
  );

  logic_74hc193_updown_counter #(.WIDTH(4), .MODULUS(16)) u_c0 (
    .ck_i(ck), .nclr_i(c_nclr), .nload_i(c_nload), .enp_i(c_enp), .ent_i(c_ent),
    .up_i(c_up), .datain_i(c_din), .co_o(c0_co), .bo_o(c0_bo), .tc_pulse_o(c0_tc),
    .counter_o(c0_cnt)
  );

  logic_74hc193_updown_counter #(.WIDTH(4), .MODULUS(16)) u_c1 (
    .ck_i(ck), .nclr_i(c_nclr), .nload_i(c_nload), .enp_i(c_enp), .ent_i(c0_co),
    .up_i(c_up), .datain_i(c_din), .co_o(c1_co), .bo_o(c1_bo), .tc_pulse_o(c1_tc),
    .counter_o(c1_cnt)
  );

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        tc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] cnt, input logic tc);
    exp_t e;
    e.tag = tag;
    e.cnt = cnt;
    e.tc  = tc;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] cnt, input logic tc);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/cnt"}, 32'(cnt), 32'(e.cnt));
      chk({e.tag, "/tc"}, 32'(tc), 32'(e.tc));
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] e0, e1;
    logic       co0;

    // Reset: clear wins over load and count for two edges on every stage
    a_nclr = 0; a_nload = 0; a_enp = 1; a_ent = 1; a_up = 0; a_din = 4'h9;
    b_nclr = 0; b_nload = 0; b_enp = 1; b_ent = 1; b_up = 0; b_din = 4'h9;
    c_nclr = 0; c_nload = 0; c_enp = 1; c_ent = 1; c_up = 0; c_din = 4'h9;
    for (int i = 0; i < 2; i++) begin
      push("rst_a", 16'h0, 1'b0);
      push("rst_b", 16'h0, 1'b0);
      push("rst_c", 16'h0, 1'b0);
      tick();
      pop_chk(16'(a_cnt), a_tc);
      pop_chk(16'(b_cnt), b_tc);
      pop_chk(16'({c1_cnt, c0_cnt}), c0_tc);
    end
    chk("rst_bo", 32'(a_bo), 32'd1);
    chk("rst_co", 32'(a_co), 32'd0);
    a_nclr = 1; b_nclr = 1; c_nclr = 1;
    a_nload = 1; b_nload = 1; c_nload = 1;
    a_enp = 0; b_enp = 0; c_enp = 0;

    // Up wrap on modulus 16: E -> F -> 0 -> 1
    a_nload = 0; a_din = 4'hE;
    push("ld_e", 16'hE, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_nload = 1; a_enp = 1; a_ent = 1; a_up = 1;
    chk("co_at_e", 32'(a_co), 32'd0);
    push("up_f", 16'hF, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    chk("co_at_f", 32'(a_co), 32'd1);
    push("up_0", Sat ? 16'hF : 16'h0, 1'b1); tick(); pop_chk(16'(a_cnt), a_tc);
    chk("co_after_wrap", 32'(a_co), Sat ? 32'd1 : 32'd0);
    push("up_1", Sat ? 16'hF : 16'h1, Sat); tick(); pop_chk(16'(a_cnt), a_tc);

    // Hold with ENT=1: lookahead stays valid and follows UP immediately
    a_nload = 0; a_din = 4'hF;
    push("ld_f", 16'hF, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_nload = 0; a_din = 4'hF;
    a_nload = 1; a_enp = 0; a_ent = 1; a_up = 1;
    chk("hold_co", 32'(a_co), 32'd1);
    push("hold_f", 16'hF, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_up = 0; #1;
    chk("dir_co", 32'(a_co), 32'd0);
    chk("dir_bo", 32'(a_bo), 32'd0);
    a_up = 1; a_ent = 0; #1;
    chk("ent_gate_co", 32'(a_co), 32'd0);

    // Priority: load beats count, clear beats load
    a_nload = 0; a_din = 4'h5;
    push("ld_5", 16'h5, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_nload = 0; a_din = 4'h3; a_enp = 1; a_ent = 1; a_up = 1;
    push("ld_over_cnt", 16'h3, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_nclr = 0; a_nload = 0;
    push("clr_over_ld", 16'h0, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_nclr = 1; a_nload = 1;
    push("cnt_after_clr", 16'h1, 1'b0); tick(); pop_chk(16'(a_cnt), a_tc);
    a_enp = 0;

    // Down wrap on modulus 10: 1 -> 0 -> 9 -> 8
    b_nload = 0; b_din = 4'h1;
    push("ld_1", 16'h1, 1'b0); tick(); pop_chk(16'(b_cnt), b_tc);
    b_nload = 1; b_enp = 1; b_ent = 1; b_up = 0;
    chk("bo_at_1", 32'(b_bo), 32'd0);
    push("dn_0", 16'h0, 1'b0); tick(); pop_chk(16'(b_cnt), b_tc);
    chk("bo_at_0", 32'(b_bo), 32'd1);
    push("dn_9", Sat ? 16'h0 : 16'h9, 1'b1); tick(); pop_chk(16'(b_cnt), b_tc);
    chk("bo_after_wrap", 32'(b_bo), Sat ? 32'd1 : 32'd0);
    push("dn_8", Sat ? 16'h0 : 16'h8, Sat); tick(); pop_chk(16'(b_cnt), b_tc);

    // Out-of-range load on modulus 10
    b_nload = 0; b_din = 4'hC;
    push("ld_c_up", 16'hC, 1'b0); tick(); pop_chk(16'(b_cnt), b_tc);
    b_nload = 1; b_up = 1;
    chk("co_oor", 32'(b_co), 32'd0);
    push("oor_up", Sat ? 16'hC : 16'h0, 1'b1); tick(); pop_chk(16'(b_cnt), b_tc);
    b_nload = 0; b_din = 4'hC;
    push("ld_c_dn", 16'hC, 1'b0); tick(); pop_chk(16'(b_cnt), b_tc);
    b_nload = 1; b_up = 0;
    push("oor_dn", 16'h9, 1'b0); tick(); pop_chk(16'(b_cnt), b_tc);
    b_enp = 0;

    // Cascade: 256 up edges from 0
    c_enp = 1; c_ent = 1; c_up = 1;
    e0 = 4'h0; e1 = 4'h0;
    for (int i = 0; i < 256; i++) begin
      co0 = (e0 == 4'hF);
      if (co0) e1 = (Sat && e1 == 4'hF) ? 4'hF : e1 + 4'h1;
      e0 = (Sat && co0) ? 4'hF : e0 + 4'h1;
      push($sformatf("casc_%0d", i), 16'({e1, e0}), co0);
      tick();
      pop_chk(16'({c1_cnt, c0_cnt}), c0_tc);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
